ex_mem_stage: RTL

EX_MEM_STAGE -- requirements
Module: ex_mem_stage

---
 rtl/ex_mem_stage.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: execute-to-memory pipeline register with valid/ready handshake
// and a registered branch redirect (pcSrc/pcTarget).
// Optional build macro EX_MEM_SKID_EN: adds a second (skid) entry so inReady can
// come straight from a flop, breaking the outReady -> inReady combinational path
// while keeping full throughput. Without it the stage holds a single entry.
module ex_mem_stage #(
    parameter int DATA_W = 64,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic              inValid,
    output logic              inReady,
    input  logic [DATA_W-1:0] aluResult,
    input  logic              zeroFlag,
    input  logic [DATA_W-1:0] storeData,
    input  logic [DATA_W-1:0] branchTarget,
    input  logic [REG_AW-1:0] rdAddr,
    input  logic              branch,
    input  logic              memRead,
    input  logic              memWrite,
    input  logic              regWrite,
    input  logic              memToReg,
    input  logic              flush,
    output logic              outValid,
    input  logic              outReady,
    output logic [DATA_W-1:0] outAluResult,
    output logic [DATA_W-1:0] outStoreData,
    output logic [REG_AW-1:0] outRdAddr,
    output logic              outMemRead,
    output logic              outMemWrite,
    output logic              outRegWrite,
    output logic              outMemToReg,
    output logic              pcSrc,
    output logic [DATA_W-1:0] pcTarget
);

    // Everything the memory stage needs from one execute-stage entry.
    typedef struct packed {
        logic [DATA_W-1:0] alu_result;
        logic [DATA_W-1:0] store_data;
        logic [REG_AW-1:0] rd_addr;
        logic              mem_read;
        logic              mem_write;
        logic              reg_write;
        logic              mem_to_reg;
    } entry_t;

    entry_t            in_entry;
    entry_t            main_q;
    entry_t            main_d;
    logic              main_valid_q;
    logic              main_valid_d;
    logic              pc_src_q;
    logic              pc_src_d;
    logic [DATA_W-1:0] pc_target_q;
    logic [DATA_W-1:0] pc_target_d;
    logic              accept;
    logic              out_fire;

    assign in_entry.alu_result = aluResult;
    assign in_entry.store_data = storeData;
    assign in_entry.rd_addr    = rdAddr;
    assign in_entry.mem_read   = memRead;
    assign in_entry.mem_write  = memWrite;
    assign in_entry.reg_write  = regWrite;
    assign in_entry.mem_to_reg = memToReg;

    assign accept   = inValid && inReady;
    assign out_fire = main_valid_q && outReady;

`ifdef EX_MEM_SKID_EN
    entry_t skid_q;
    entry_t skid_d;
    logic   skid_valid_q;
    logic   skid_valid_d;
    logic   ready_q;
    logic   ready_d;

    // Ready comes from a flop; flush still blocks acceptance in its own cycle.
    assign inReady = ready_q && !flush;

    // Next state of the output (main) entry and the overflow (skid) entry.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        main_d       = main_q;
        main_valid_d = main_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q || out_fire) begin
            // Main slot is free this edge: oldest entry (skid first) moves in.
            if (skid_valid_q) begin
                main_d       = skid_q;
                main_valid_d = 1'b1;
                skid_valid_d = 1'b0;
            end else begin
                main_valid_d = accept;
                if (accept) begin
                    main_d = in_entry;
                end
            end
        end else if (accept) begin
            // Main is stalled; park the new entry behind it.
            skid_d       = in_entry;
            skid_valid_d = 1'b1;
        end
        // The skid slot only fills while main is full, so it alone marks "both full".
        ready_d = !skid_valid_d;
    end

    // Skid entry and registered ready.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
            ready_q      <= 1'b1;
        end else begin
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
            ready_q      <= ready_d;
        end
    end
`else
    // Single entry: accept when the slot is empty or draining this edge.
    assign inReady = (!main_valid_q || outReady) && !flush;

    // Next state of the single output entry.
    always_comb begin
        main_d       = main_q;
        main_valid_d = main_valid_q;
        if (flush) begin
            main_valid_d = 1'b0;
        end else if (!main_valid_q || out_fire) begin
            main_valid_d = accept;
            if (accept) begin
                main_d = in_entry;
            end
        end
    end
`endif

    // Branch redirect: one-cycle pulse for a taken branch, target held otherwise.
    always_comb begin
        pc_src_d    = accept && branch && zeroFlag;
        pc_target_d = pc_src_d ? branchTarget : pc_target_q;
    end

    // Output entry and branch redirect registers.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            // NOTE: the data slots are reset too, because the out* ports must read 0 during reset.
            main_q       <= '0;
            main_valid_q <= 1'b0;
            pc_src_q     <= 1'b0;
            pc_target_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            main_q       <= main_d;
            main_valid_q <= main_valid_d;
            pc_src_q     <= pc_src_d;
            pc_target_q  <= pc_target_d;
        end
    end

    assign outValid     = main_valid_q;
    assign outAluResult = main_q.alu_result;
    assign outStoreData = main_q.store_data;
    assign outRdAddr    = main_q.rd_addr;
    assign outMemRead   = main_q.mem_read;
    assign outMemWrite  = main_q.mem_write;
    assign outRegWrite  = main_q.reg_write;
    assign outMemToReg  = main_q.mem_to_reg;
    assign pcSrc        = pc_src_q;
    assign pcTarget     = pc_target_q;

endmodule
